// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage: instruction field layout,
// ALU opcode values and the small decode helpers used at issue.
package operand_fetch_pkg;

  localparam int INSTR_W  = 16;

  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 12;
  localparam int FLAG_BIT = 11;
  localparam int RD_HI    = 10;
  localparam int RD_LO    = 8;
  localparam int RS1_HI   = 7;
  localparam int RS1_LO   = 5;
  localparam int RS2_HI   = 4;
  localparam int RS2_LO   = 2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_EQ  = 4'b1001;
  localparam logic [3:0] OP_NE  = 4'b1010;
  localparam logic [3:0] OP_LT  = 4'b1011;
  localparam logic [3:0] OP_GE  = 4'b1100;

  // Decoded view of one instruction word.
  typedef struct packed {
    logic [3:0] opcode;
    logic       flag;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
  } instr_fields_t;

  function automatic instr_fields_t decode(input logic [INSTR_W-1:0] instr);
    instr_fields_t f;
    f.opcode = instr[OPC_HI:OPC_LO];
    f.flag   = instr[FLAG_BIT];
    f.rd     = instr[RD_HI:RD_LO];
    f.rs1    = instr[RS1_HI:RS1_LO];
    f.rs2    = instr[RS2_HI:RS2_LO];
    return f;
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_XOR, OP_AND, OP_NOT,
      OP_EQ, OP_NE, OP_LT, OP_GE: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  // NOT is the only single-operand op; its rs2 field is don't-care.
  function automatic logic uses_rs2(input logic [3:0] op);
    return (op != OP_NOT);
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Bus bundle between the instruction source, the operand fetch stage,
// the ALU and the writeback path. The stage itself uses the slave view.
interface operand_fetch_if
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;

  logic               ex_valid;
  logic               ex_ready;
  logic [3:0]         ex_opcode;
  logic               ex_flag;
  logic [DATA_W-1:0]  ex_rega;
  logic [DATA_W-1:0]  ex_regb;
  logic [REG_AW-1:0]  ex_rd;

  logic               wb_en;
  logic [REG_AW-1:0]  wb_addr;
  logic [DATA_W-1:0]  wb_data;

  logic               err_illegal;

  modport slave (
    input  in_valid, in_instr, ex_ready, wb_en, wb_addr, wb_data,
    output in_ready, ex_valid, ex_opcode, ex_flag, ex_rega, ex_regb, ex_rd,
           err_illegal
  );

  modport master (
    output in_valid, in_instr, ex_ready, wb_en, wb_addr, wb_data,
    input  in_ready, ex_valid, ex_opcode, ex_flag, ex_rega, ex_regb, ex_rd,
           err_illegal
  );
endinterface

// File: rtl/operand_fetch_regfile_2r1w.sv
// Register file with two combinational read ports and one write port.
// r0 is hard-wired to zero; a read of the register being written this
// cycle returns the incoming write data.
module regfile_2r1w #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);
  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] mem [NREG];

  // Storage update; writes aimed at r0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port A with write-through.
  always_comb begin
    rdata_a = mem[raddr_a];
    if (raddr_a == '0)                      rdata_a = '0;
    else if (we && (waddr == raddr_a))      rdata_a = wdata;
  end

  // Read port B with write-through.
  always_comb begin
    rdata_b = mem[raddr_b];
    if (raddr_b == '0)                      rdata_b = '0;
    else if (we && (waddr == raddr_b))      rdata_b = wdata;
  end

endmodule

// File: rtl/operand_fetch.sv
// Issue stage in front of the 16-bit ALU: decodes instructions, reads
// operands, blocks on in-flight destinations and holds one registered
// output slot towards the ALU.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic clk,
  input  logic rst_n,
  operand_fetch_if.slave bus
);
  localparam int NREG = 1 << REG_AW;

  instr_fields_t     f;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic              legal, use_rs2;
  logic [DATA_W-1:0] rdata_a, rdata_b, opb;

  logic [NREG-1:0]   pending_q, pending_d;
  logic              wb_clr;
  logic              rs1_busy, rs2_busy, rd_busy, stall;
  logic              slot_free, in_ready, issue, illegal_take;

  logic              ex_valid_q;
  logic [3:0]        ex_opcode_q;
  logic              ex_flag_q;
  logic [DATA_W-1:0] ex_rega_q, ex_regb_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic              err_q;

  assign f       = decode(bus.in_instr);
  assign rd      = f.rd;
  assign rs1     = f.rs1;
  assign rs2     = f.rs2;
  assign legal   = is_legal(f.opcode);
  assign use_rs2 = uses_rs2(f.opcode);

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bus.wb_en),
    .waddr   (bus.wb_addr),
    .wdata   (bus.wb_data),
    .raddr_a (rs1),
    .rdata_a (rdata_a),
    .raddr_b (rs2),
    .rdata_b (rdata_b)
  );

  assign opb = use_rs2 ? rdata_b : '0;

  // A writeback landing this cycle releases its register for hazard purposes.
  assign wb_clr   = bus.wb_en && (bus.wb_addr != '0);
  assign rs1_busy = pending_q[rs1] && !(wb_clr && (bus.wb_addr == rs1));
  assign rs2_busy = pending_q[rs2] && !(wb_clr && (bus.wb_addr == rs2));
  assign rd_busy  = pending_q[rd]  && !(wb_clr && (bus.wb_addr == rd));
  assign stall    = rs1_busy || (use_rs2 && rs2_busy) || ((rd != '0) && rd_busy);

  assign slot_free    = !ex_valid_q || bus.ex_ready;
  assign in_ready     = slot_free && !(bus.in_valid && legal && stall);
  assign issue        = bus.in_valid && in_ready && legal;
  assign illegal_take = bus.in_valid && slot_free && !legal;

  // Scoreboard update: clear on writeback first so a same-cycle issue to that register wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_clr)             pending_d[bus.wb_addr] = 1'b0;
    if (issue && rd != '0)  pending_d[rd]          = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // Output slot: load on issue, empty on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_opcode_q <= '0;
      ex_flag_q   <= 1'b0;
      ex_rega_q   <= '0;
      ex_regb_q   <= '0;
      ex_rd_q     <= '0;
    end else if (issue) begin
      ex_valid_q  <= 1'b1;
      ex_opcode_q <= f.opcode;
      ex_flag_q   <= f.flag;
      ex_rega_q   <= rdata_a;
      ex_regb_q   <= opb;
      ex_rd_q     <= rd;
    end else if (bus.ex_ready) begin
      ex_valid_q  <= 1'b0;
    end
  end

  // Illegal-opcode pulse, one cycle after the instruction is swallowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= illegal_take;
  end

  assign bus.in_ready    = in_ready;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_opcode   = ex_opcode_q;
  assign bus.ex_flag     = ex_flag_q;
  assign bus.ex_rega     = ex_rega_q;
  assign bus.ex_regb     = ex_regb_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.err_illegal = err_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a per-cycle vector table plus a
// hand-written reset-mid-transaction sequence.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  operand_fetch_if #(.DATA_W(16), .REG_AW(3)) bus_if ();

  operand_fetch #(.DATA_W(16), .REG_AW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        iv;
    logic [15:0] instr;
    logic        er;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        x_in_ready;
    logic        x_valid;
    logic [3:0]  x_op;
    logic        x_flag;
    logic [15:0] x_a;
    logic [15:0] x_b;
    logic [2:0]  x_rd;
    logic        x_err;
  } vec_t;

  vec_t vq[$];

  function automatic logic [15:0] enc(input logic [3:0] op, input logic fl,
                                      input logic [2:0] rd, input logic [2:0] rs1,
                                      input logic [2:0] rs2);
    return {op, fl, rd, rs1, rs2, 2'b00};
  endfunction

  function automatic void add_vec(input logic iv, input logic [15:0] instr,
                                  input logic er, input logic we, input logic [2:0] wa,
                                  input logic [15:0] wd, input logic x_in_ready,
                                  input logic x_valid, input logic [3:0] x_op,
                                  input logic x_flag, input logic [15:0] x_a,
                                  input logic [15:0] x_b, input logic [2:0] x_rd,
                                  input logic x_err);
    vec_t v;
    v.iv = iv; v.instr = instr; v.er = er; v.we = we; v.wa = wa; v.wd = wd;
    v.x_in_ready = x_in_ready; v.x_valid = x_valid; v.x_op = x_op;
    v.x_flag = x_flag; v.x_a = x_a; v.x_b = x_b; v.x_rd = x_rd; v.x_err = x_err;
    vq.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus_if.in_valid = v.iv;
    bus_if.in_instr = v.instr;
    bus_if.ex_ready = v.er;
    bus_if.wb_en    = v.we;
    bus_if.wb_addr  = v.wa;
    bus_if.wb_data  = v.wd;
  endtask

  task automatic check_slot(input string tag, input vec_t v);
    checkOutput({tag, ".ex_valid"}, 16'(bus_if.ex_valid), 16'(v.x_valid));
    checkOutput({tag, ".err"}, 16'(bus_if.err_illegal), 16'(v.x_err));
    if (v.x_valid) begin
      checkOutput({tag, ".op"},   16'(bus_if.ex_opcode), 16'(v.x_op));
      checkOutput({tag, ".flag"}, 16'(bus_if.ex_flag),   16'(v.x_flag));
      checkOutput({tag, ".rega"}, bus_if.ex_rega,        v.x_a);
      checkOutput({tag, ".regb"}, bus_if.ex_regb,        v.x_b);
      checkOutput({tag, ".rd"},   16'(bus_if.ex_rd),     16'(v.x_rd));
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, ".ex_valid"}, 16'(bus_if.ex_valid),    16'h0);
    checkOutput({tag, ".op"},       16'(bus_if.ex_opcode),   16'h0);
    checkOutput({tag, ".flag"},     16'(bus_if.ex_flag),     16'h0);
    checkOutput({tag, ".rega"},     bus_if.ex_rega,          16'h0);
    checkOutput({tag, ".regb"},     bus_if.ex_regb,          16'h0);
    checkOutput({tag, ".rd"},       16'(bus_if.ex_rd),       16'h0);
    checkOutput({tag, ".err"},      16'(bus_if.err_illegal), 16'h0);
  endtask

  initial begin
    vec_t v;
    logic [15:0] i_raw, i_xor, i_ill, i_not, i_ge, i_lt, i_ill2;

    i_raw  = enc(OP_SUB, 1'b1, 3'd4, 3'd1, 3'd2);
    i_xor  = enc(OP_XOR, 1'b0, 3'd5, 3'd2, 3'd3);
    i_ill  = enc(4'b1110, 1'b0, 3'd6, 3'd4, 3'd0);
    i_not  = enc(OP_NOT, 1'b0, 3'd7, 3'd3, 3'd5);
    i_ge   = enc(OP_GE, 1'b1, 3'd1, 3'd3, 3'd0);
    i_lt   = enc(OP_LT, 1'b0, 3'd2, 3'd0, 3'd0);
    i_ill2 = enc(4'b0110, 1'b0, 3'd1, 3'd0, 3'd0);

    //      iv  instr                          er  we wa    wd       rdy vld op      fl a        b        rd    err
    add_vec(0, 16'h0,                          1, 1, 3'd2, 16'd5,   1, 0, 4'h0,   0, 16'h0,    16'h0,   3'd0, 0);
    add_vec(0, 16'h0,                          1, 1, 3'd3, 16'd7,   1, 0, 4'h0,   0, 16'h0,    16'h0,   3'd0, 0);
    add_vec(1, enc(OP_ADD, 0, 3'd1, 3'd2, 3'd3), 1, 0, 3'd0, 16'h0, 1, 1, OP_ADD, 0, 16'd5,    16'd7,   3'd1, 0);
    add_vec(1, i_raw,                          1, 0, 3'd0, 16'h0,   0, 0, 4'h0,   0, 16'h0,    16'h0,   3'd0, 0);
    add_vec(1, i_raw,                          1, 0, 3'd0, 16'h0,   0, 0, 4'h0,   0, 16'h0,    16'h0,   3'd0, 0);
    add_vec(1, i_raw,                          1, 1, 3'd1, 16'h00FF, 1, 1, OP_SUB, 1, 16'h00FF, 16'd5,   3'd4, 0);
    add_vec(1, i_xor,                          0, 0, 3'd0, 16'h0,   0, 1, OP_SUB, 1, 16'h00FF, 16'd5,   3'd4, 0);
    add_vec(1, i_xor,                          0, 0, 3'd0, 16'h0,   0, 1, OP_SUB, 1, 16'h00FF, 16'd5,   3'd4, 0);
    add_vec(1, i_xor,                          0, 0, 3'd0, 16'h0,   0, 1, OP_SUB, 1, 16'h00FF, 16'd5,   3'd4, 0);
    add_vec(1, i_xor,                          1, 0, 3'd0, 16'h0,   1, 1, OP_XOR, 0, 16'd5,    16'd7,   3'd5, 0);
    add_vec(1, i_ill,                          1, 0, 3'd0, 16'h0,   1, 0, 4'h0,   0, 16'h0,    16'h0,   3'd0, 1);
    add_vec(0, 16'h0,                          1, 0, 3'd0, 16'h0,   1, 0, 4'h0,   0, 16'h0,    16'h0,   3'd0, 0);
    add_vec(1, enc(OP_AND, 0, 3'd6, 3'd2, 3'd0), 1, 0, 3'd0, 16'h0, 1, 1, OP_AND, 0, 16'd5,    16'h0,   3'd6, 0);
    add_vec(1, i_not,                          1, 0, 3'd0, 16'h0,   1, 1, OP_NOT, 0, 16'd7,    16'h0,   3'd7, 0);
    add_vec(0, 16'h0,                          1, 1, 3'd0, 16'hFFFF, 1, 0, 4'h0,  0, 16'h0,    16'h0,   3'd0, 0);
    add_vec(1, enc(OP_OR, 1, 3'd2, 3'd0, 3'd1), 1, 0, 3'd0, 16'h0,  1, 1, OP_OR,  1, 16'h0,    16'h00FF, 3'd2, 0);
    add_vec(1, enc(OP_EQ, 0, 3'd3, 3'd0, 3'd0), 1, 1, 3'd3, 16'h1234, 1, 1, OP_EQ, 0, 16'h0,   16'h0,   3'd3, 0);
    add_vec(1, i_ge,                           1, 0, 3'd0, 16'h0,   0, 0, 4'h0,   0, 16'h0,    16'h0,   3'd0, 0);
    add_vec(1, i_ge,                           1, 1, 3'd3, 16'hABCD, 1, 1, OP_GE, 1, 16'hABCD, 16'h0,   3'd1, 0);
    add_vec(1, i_lt,                           1, 0, 3'd0, 16'h0,   0, 0, 4'h0,   0, 16'h0,    16'h0,   3'd0, 0);
    add_vec(1, i_lt,                           1, 1, 3'd2, 16'h0042, 1, 1, OP_LT, 0, 16'h0,    16'h0,   3'd2, 0);
    add_vec(1, i_ill2,                         0, 0, 3'd0, 16'h0,   0, 1, OP_LT,  0, 16'h0,    16'h0,   3'd2, 0);
    add_vec(1, i_ill2,                         1, 0, 3'd0, 16'h0,   1, 0, 4'h0,   0, 16'h0,    16'h0,   3'd0, 1);
    add_vec(0, 16'h0,                          1, 0, 3'd0, 16'h0,   1, 0, 4'h0,   0, 16'h0,    16'h0,   3'd0, 0);

    // Reset state.
    rst_n = 1'b0;
    v = '{default: '0};
    applyStimulus(v);
    #12;
    check_all_zero("reset");
    checkOutput("reset.in_ready", 16'(bus_if.in_ready), 16'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table, one cycle per row.
    foreach (vq[k]) begin
      @(negedge clk);
      applyStimulus(vq[k]);
      #1;
      checkOutput($sformatf("v%0d.in_ready", k), 16'(bus_if.in_ready),
                  16'(vq[k].x_in_ready));
      @(posedge clk);
      #1;
      check_slot($sformatf("v%0d", k), vq[k]);
    end

    // Reset while the slot is held and r4 is still pending.
    @(negedge clk);
    v = '{default: '0};
    v.iv = 1'b1; v.instr = enc(OP_NE, 1'b0, 3'd0, 3'd0, 3'd0); v.er = 1'b0;
    applyStimulus(v);
    #1;
    checkOutput("rst_seq.in_ready", 16'(bus_if.in_ready), 16'h1);
    @(posedge clk);
    #1;
    checkOutput("rst_seq.loaded", 16'(bus_if.ex_valid), 16'h1);
    #2;
    rst_n = 1'b0;
    v = '{default: '0};
    applyStimulus(v);
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    v = '{default: '0};
    v.iv = 1'b1; v.instr = enc(OP_ADD, 1'b0, 3'd5, 3'd4, 3'd2); v.er = 1'b1;
    v.x_valid = 1'b1; v.x_op = OP_ADD; v.x_a = 16'h0; v.x_b = 16'h0; v.x_rd = 3'd5;
    applyStimulus(v);
    #1;
    checkOutput("post_rst.in_ready", 16'(bus_if.in_ready), 16'h1);
    @(posedge clk);
    #1;
    check_slot("post_rst", v);

    @(negedge clk);
    v = '{default: '0};
    applyStimulus(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
